bcd_scan_mux: RTL and testbench

- Time-multiplexed digit scanner sitting directly upstream of the BCD-to-7-segment decoder.
- Holds a multi-digit packed BCD value and presents one nibble at a time on bcd_out, which feeds the decoder's bcd input.
- Drives active-low digit enables (anodes) in lock-step with bcd_out.
- Provides tear-free value updates, leading-zero blanking and anode dead-time; blanking uses code 4'hF, which the decoder maps to all segments off.

---
 rtl/bcd_scan_mux_if.sv | 25 ++
 rtl/bcd_scan_mux.sv | 92 +++++++++
 tb/tb_bcd_scan_mux.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_scan_mux_if.sv
// Bus between the digit scanner and its user: value/load on one side,
// decoder nibble, anode enables and scan status on the other.
interface bcd_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IW = $clog2(NUM_DIGITS);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic                    blank_lz;
  logic [3:0]              bcd_out;
  logic [NUM_DIGITS-1:0]   an;
  logic [IW-1:0]           digit_idx;
  logic                    frame_tick;

  modport master (
    output load, bcd_in, blank_lz,
    input  bcd_out, an, digit_idx, frame_tick
  );

  modport slave (
    input  load, bcd_in, blank_lz,
    output bcd_out, an, digit_idx, frame_tick
  );
endinterface

// File: rtl/bcd_scan_mux.sv
// Time-multiplexed BCD digit scanner: frame-synchronous value updates,
// leading-zero blanking (nibble 4'hF) and per-slot anode dead-time.
module bcd_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int DEAD       = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd_scan_mux_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(PRESCALE);
  localparam int W  = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_reg;
  logic [IW-1:0]         idx_reg;
  logic [W-1:0]          pending_reg;
  logic [W-1:0]          display_reg;
  logic [NUM_DIGITS-1:0] an_reg;
  logic [3:0]            bcd_out_reg;
  logic [IW-1:0]         digit_idx_reg;
  logic                  frame_tick_reg;

  logic [3:0]            digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] an_next;
  logic [3:0]            bcd_out_next;
  logic                  in_dead;
  logic                  slot_wrap;
  logic                  frame_end;

  // A digit is blanked when it and every more significant digit are zero;
  // digit 0 always shows so that a zero value reads "0".
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign digit[gi] = display_reg[4*gi +: 4];
    if (gi == 0) begin : g_lsd
      assign blank[gi] = 1'b0;
    end else begin : g_upper
      assign blank[gi] = bus.blank_lz && (display_reg[W-1:4*gi] == '0);
    end
  end

  if (DEAD == 0) begin : g_no_dead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = (cnt_reg < CW'(DEAD));
  end

  assign slot_wrap    = (cnt_reg == CNT_LAST);
  assign frame_end    = slot_wrap && (idx_reg == IDX_LAST);
  assign an_next      = in_dead ? '1 : ~(NUM_DIGITS'(1) << idx_reg);
  assign bcd_out_next = blank[idx_reg] ? 4'hF : digit[idx_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      pending_reg    <= '0;
      display_reg    <= '0;
      an_reg         <= '1;
      bcd_out_reg    <= 4'hF;
      digit_idx_reg  <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      if (bus.load) begin
        pending_reg <= bus.bcd_in;
      end
      if (slot_wrap) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      // Pre-edge pending is taken, so a load on this same edge waits a frame.
      if (frame_end) begin
        display_reg <= pending_reg;
      end
      frame_tick_reg <= frame_end;
      an_reg         <= an_next;
      bcd_out_reg    <= bcd_out_next;
      digit_idx_reg  <= idx_reg;
    end
  end

  assign bus.an         = an_reg;
  assign bus.bcd_out    = bcd_out_reg;
  assign bus.digit_idx  = digit_idx_reg;
  assign bus.frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_bcd_scan_mux.sv
// Bench for bcd_scan_mux: two instances (P=4/D=1 and P=2/D=0) driven alike and
// compared every cycle against an arithmetic model of time since reset.
module tb_bcd_scan_mux;
  localparam int N  = 4;
  localparam int PA = 4;
  localparam int DA = 1;
  localparam int PB = 2;
  localparam int DB = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_scan_mux_if #(.NUM_DIGITS(N)) bus_a ();
  bcd_scan_mux_if #(.NUM_DIGITS(N)) bus_b ();

  bcd_scan_mux #(.NUM_DIGITS(N), .PRESCALE(PA), .DEAD(DA)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  bcd_scan_mux #(.NUM_DIGITS(N), .PRESCALE(PB), .DEAD(DB)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  int          checks   = 0;
  int          failures = 0;
  int          e        = 0;   // rising edges since reset release
  logic [15:0] pend     = '0;
  logic [15:0] disp_a   = '0;
  logic [15:0] disp_b   = '0;
  logic        blz_r    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s e=%0d got=%0h want=%0h", tag, e, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] val, input logic blz);
    bus_a.load = ld;  bus_a.bcd_in = val;  bus_a.blank_lz = blz;
    bus_b.load = ld;  bus_b.bcd_in = val;  bus_b.blank_lz = blz;
  endtask

  // Outputs after edge ev follow from slot position ev/p and the value
  // on display before that edge.
  task automatic model_out(input int p, input int d, input int ev, input logic [15:0] dv,
                           input logic blz, output logic [3:0] an_e, output logic [3:0] bcd_e,
                           output logic [1:0] idx_e, output logic ft_e);
    int          cnt;
    int          idx;
    logic [15:0] above;
    cnt   = ev % p;
    idx   = (ev / p) % N;
    above = dv >> (4 * idx);
    an_e  = (cnt < d) ? 4'hF : (4'hF ^ (4'h1 << idx));
    bcd_e = (blz && idx > 0 && above == 16'h0) ? 4'hF : above[3:0];
    idx_e = 2'(idx);
    ft_e  = ((ev % (p * N)) == (p * N - 1));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an_a"},  bus_a.an,         4'hF);
    chk({tag, "_bcd_a"}, bus_a.bcd_out,    4'hF);
    chk({tag, "_idx_a"}, bus_a.digit_idx,  2'd0);
    chk({tag, "_ft_a"},  bus_a.frame_tick, 1'b0);
    chk({tag, "_an_b"},  bus_b.an,         4'hF);
    chk({tag, "_bcd_b"}, bus_b.bcd_out,    4'hF);
    chk({tag, "_ft_b"},  bus_b.frame_tick, 1'b0);
  endtask

  task automatic step(input logic ld, input logic [15:0] val, input logic blz);
    logic [3:0] an_a, bcd_a, an_b, bcd_b;
    logic [1:0] idx_a, idx_b;
    logic       ft_a, ft_b;
    @(negedge clk);
    drive(ld, val, blz);
    model_out(PA, DA, e, disp_a, blz, an_a, bcd_a, idx_a, ft_a);
    model_out(PB, DB, e, disp_b, blz, an_b, bcd_b, idx_b, ft_b);
    @(posedge clk);
    #1;
    chk("an_a",  bus_a.an,         an_a);
    chk("bcd_a", bus_a.bcd_out,    bcd_a);
    chk("idx_a", bus_a.digit_idx,  idx_a);
    chk("ft_a",  bus_a.frame_tick, ft_a);
    chk("an_b",  bus_b.an,         an_b);
    chk("bcd_b", bus_b.bcd_out,    bcd_b);
    chk("idx_b", bus_b.digit_idx,  idx_b);
    chk("ft_b",  bus_b.frame_tick, ft_b);
    if ((e % (PA * N)) == PA * N - 1) disp_a = pend;
    if ((e % (PB * N)) == PB * N - 1) disp_b = pend;
    if (ld) begin
      pend = val;
      $display("load value=%h blank_lz=%0d at edge %0d", val, blz, e);
    end
    e++;
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] v;
    for (int i = 0; i < N; i++) begin
      v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  task automatic restart();
    e      = 0;
    pend   = '0;
    disp_a = '0;
    disp_b = '0;
  endtask

  initial begin
    drive(1'b0, 16'h0, 1'b0);

    // Reset held while inputs toggle
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'b1);
      @(posedge clk);
      #1;
      chk_reset("rst_hold");
    end
    #1 rst_n = 1'b1;
    restart();

    // Plain scan of 1234
    step(1'b1, 16'h1234, 1'b0);
    repeat (40) step(1'b0, 16'h0, 1'b0);

    // Mid-frame load must not tear the current frame
    while ((e % (PA * N)) != 6) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h5678, 1'b0);
    repeat (30) step(1'b0, 16'h0, 1'b0);

    // Load exactly on the frame-boundary edge
    while ((e % (PA * N)) != PA * N - 1) step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'h9999, 1'b0);
    repeat (40) step(1'b0, 16'h0, 1'b0);

    // Leading-zero blanking cases
    step(1'b1, 16'h0047, 1'b1);
    repeat (36) step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    repeat (36) step(1'b0, 16'h0, 1'b1);
    step(1'b1, 16'h0407, 1'b1);
    repeat (36) step(1'b0, 16'h0, 1'b1);

    // Randomized loads, values and blank_lz toggling
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) blz_r = ~blz_r;
      step(1'($urandom_range(0, 7) == 0), rand_value(), blz_r);
    end

    // Asynchronous reset mid-slot
    step(1'b1, 16'h4321, 1'b0);
    while ((e % PA) != 2) step(1'b0, 16'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("rst_async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_reset("rst_async_hold");
    end
    #1 rst_n = 1'b1;
    restart();
    repeat (20) step(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 5) == 0), rand_value(), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
